// File: rtl/tank_game_pkg.sv
// tank_game_pkg: shared slot state type, tank identifiers and counter widths
package tank_game_pkg;
    typedef enum logic {SLOT_FREE, SLOT_FLYING} slot_state_e;
    localparam logic TANK1 = 1'b0;
    localparam logic TANK2 = 1'b1;
    localparam int AGE_W = 10;
    localparam int CD_W = 6;
endpackage

// File: rtl/bullet_slot_ctrl.sv
// bullet_slot_ctrl: one bullet slot -- FREE/FLYING state, frame-age counter, owner register
//   CLK, RESET   clock, synchronous active-high reset
//   tick         one-cycle frame strobe
//   flush        forces the slot FREE on the next cycle (round not in play)
//   grant        allocate this slot; owner_in is the tank being granted
//   hit          tank collision, frees a FLYING slot on the next cycle
//   create       one-cycle pulse after the slot is allocated
//   active       slot is FLYING
//   owner        owning tank, held while FLYING
module bullet_slot_ctrl
    import tank_game_pkg::*;
#(
    parameter logic [AGE_W-1:0] LIFETIME = 10'd300
) (
    input  logic CLK,
    input  logic RESET,
    input  logic tick,
    input  logic flush,
    input  logic grant,
    input  logic owner_in,
    input  logic hit,
    output logic create,
    output logic active,
    output logic owner
);
    slot_state_e state, state_nx;
    logic [AGE_W-1:0] age, age_nx;
    logic owner_nx;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= SLOT_FREE;
            age    <= '0;
            owner  <= TANK1;
            create <= 1'b0;
        end else begin
            state  <= state_nx;
            age    <= age_nx;
            owner  <= owner_nx;
            create <= grant & (state == SLOT_FREE) & ~flush;
        end
    end

    // hit outranks expiry; an expiring slot is still FLYING during its last tick
    always_comb begin
        state_nx = state;
        age_nx   = age;
        owner_nx = owner;
        if (flush)
            state_nx = SLOT_FREE;
        else if (state == SLOT_FREE) begin
            if (grant) begin
                state_nx = SLOT_FLYING;
                age_nx   = LIFETIME;
                owner_nx = owner_in;
            end
        end else if (hit)
            state_nx = SLOT_FREE;
        else if (tick) begin
            age_nx   = age - AGE_W'(1);
            state_nx = (age == AGE_W'(1)) ? SLOT_FREE : SLOT_FLYING;
        end
    end

    assign active = (state == SLOT_FLYING);
endmodule

// File: rtl/bullet_pool_arbiter.sv
// bullet_pool_arbiter: allocates bullet slots to two tanks once per frame with live limit and cooldown
//   CLK, RESET        clock, synchronous active-high reset
//   vs                VGA vsync (active-low); its falling edge is the frame tick
//   game_active       round in play; low frees every slot and clears cooldowns
//   fire_req[1:0]     level fire request, bit 0 tank1, bit 1 tank2
//   slot_hit          per-slot collision, frees that slot next cycle
//   fire_grant[1:0]   one-cycle pulse per accepted request
//   slot_create       one-cycle pulse to each bullet's create input
//   slot_owner        0 tank1, 1 tank2
//   slot_active       slot is FLYING
//   live_count1/2     registered count of live slots per tank
// Build option BULLET_POOL_SHARED_EN: any slot serves either tank with round-robin
// contention; otherwise the lower half of the pool is tank1's and the upper half tank2's.
module bullet_pool_arbiter
    import tank_game_pkg::*;
#(
    parameter int NUM_SLOTS = 6,
    parameter int MAX_PER_TANK = 3,
    parameter logic [AGE_W-1:0] LIFETIME = 10'd300,
    parameter logic [CD_W-1:0] COOLDOWN = 6'd8
) (
    input  logic CLK,
    input  logic RESET,
    input  logic vs,
    input  logic game_active,
    input  logic [1:0] fire_req,
    input  logic [NUM_SLOTS-1:0] slot_hit,
    output logic [1:0] fire_grant,
    output logic [NUM_SLOTS-1:0] slot_create,
    output logic [NUM_SLOTS-1:0] slot_owner,
    output logic [NUM_SLOTS-1:0] slot_active,
    output logic [2:0] live_count1,
    output logic [2:0] live_count2
);
`ifdef BULLET_POOL_SHARED_EN
    localparam int MAX_EFF = MAX_PER_TANK;
`else
    localparam int HALF = NUM_SLOTS / 2;
    localparam int MAX_EFF = (MAX_PER_TANK < HALF) ? MAX_PER_TANK : HALF;
    localparam logic [NUM_SLOTS-1:0] HI_MASK = {NUM_SLOTS{1'b1}} << HALF;
`endif
    localparam logic [2:0] MAX_EFF3 = 3'(MAX_EFF);

    logic vs_d, tick;
    logic [1:0] req_prev, elig, has_free, grant_now;
    logic [CD_W-1:0] cd [2];
    logic [2:0] cnt1, cnt2;
    logic [NUM_SLOTS-1:0] free, gnt1, gnt2, own_in;

    assign tick = vs_d & ~vs;
    assign free = ~slot_active;
    assign cnt1 = 3'($countones(slot_active & ~slot_owner));
    assign cnt2 = 3'($countones(slot_active & slot_owner));

    assign elig[0] = tick & game_active & fire_req[0] & ~req_prev[0] & (cd[0] == '0)
                   & (cnt1 < MAX_EFF3) & has_free[0];
    assign elig[1] = tick & game_active & fire_req[1] & ~req_prev[1] & (cd[1] == '0)
                   & (cnt2 < MAX_EFF3) & has_free[1];

`ifdef BULLET_POOL_SHARED_EN
    logic ptr;
    logic [NUM_SLOTS-1:0] f1, f2, rest;
    // x & -x isolates the lowest set bit: f1 lowest free slot, f2 the next one
    assign f1 = free & -free;
    assign rest = free & ~f1;
    assign f2 = rest & -rest;
    assign has_free = {2{|free}};
    // under contention the pointer's tank takes f1; the other gets f2, empty if only one was free
    assign gnt1 = elig[0] ? ((&elig && ptr == TANK2) ? f2 : f1) : '0;
    assign gnt2 = elig[1] ? ((&elig && ptr == TANK1) ? f2 : f1) : '0;
    assign own_in = gnt2;
    always_ff @(posedge CLK)
        ptr <= RESET ? TANK1 : (&elig ? ~ptr : ptr);
`else
    logic [NUM_SLOTS-1:0] fr1, fr2;
    assign fr1 = free & ~HI_MASK;
    assign fr2 = free & HI_MASK;
    assign has_free = {|fr2, |fr1};
    assign gnt1 = elig[0] ? (fr1 & -fr1) : '0;
    assign gnt2 = elig[1] ? (fr2 & -fr2) : '0;
    assign own_in = HI_MASK;
`endif

    assign grant_now = {|gnt2, |gnt1};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            vs_d        <= 1'b0;
            req_prev    <= '0;
            fire_grant  <= '0;
            cd[0]       <= '0;
            cd[1]       <= '0;
            live_count1 <= '0;
            live_count2 <= '0;
        end else begin
            vs_d        <= vs;
            req_prev    <= tick ? fire_req : req_prev;
            fire_grant  <= grant_now;
            live_count1 <= cnt1;
            live_count2 <= cnt2;
            for (int t = 0; t < 2; t++)
                cd[t] <= !game_active ? '0 :
                         grant_now[t] ? COOLDOWN :
                         (tick && cd[t] != '0) ? cd[t] - CD_W'(1) : cd[t];
        end
    end

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        bullet_slot_ctrl #(.LIFETIME(LIFETIME)) u_slot (
            .CLK      (CLK),
            .RESET    (RESET),
            .tick     (tick),
            .flush    (~game_active),
            .grant    (gnt1[i] | gnt2[i]),
            .owner_in (own_in[i]),
            .hit      (slot_hit[i]),
            .create   (slot_create[i]),
            .active   (slot_active[i]),
            .owner    (slot_owner[i])
        );
    end
endmodule

// File: tb/tb_bullet_pool_arbiter.sv
// tb_bullet_pool_arbiter: directed scenarios plus randomized frames against a bullet-list model
module tb_bullet_pool_arbiter;
    localparam int N = 6;
    localparam int MAXP = 3;
    localparam int LIFE = 300;
    localparam int CDN = 8;
`ifdef BULLET_POOL_SHARED_EN
    localparam bit SHARED = 1'b1;
`else
    localparam bit SHARED = 1'b0;
`endif
    localparam int MAXE = SHARED ? MAXP : ((MAXP < N / 2) ? MAXP : N / 2);

    logic CLK = 1'b0;
    logic RESET, vs, game_active;
    logic [1:0] fire_req, fire_grant;
    logic [N-1:0] slot_hit, slot_create, slot_owner, slot_active;
    logic [2:0] live_count1, live_count2;
    int n_cmp = 0;
    int n_bad = 0;

    always #10 CLK = ~CLK;

    bullet_pool_arbiter #(
        .NUM_SLOTS(N), .MAX_PER_TANK(MAXP), .LIFETIME(10'(LIFE)), .COOLDOWN(6'(CDN))
    ) dut (
        .CLK(CLK), .RESET(RESET), .vs(vs), .game_active(game_active),
        .fire_req(fire_req), .slot_hit(slot_hit), .fire_grant(fire_grant),
        .slot_create(slot_create), .slot_owner(slot_owner), .slot_active(slot_active),
        .live_count1(live_count1), .live_count2(live_count2)
    );

    // reference model: a list of bullets with owner and remaining frames, per-tank cooldown frames
    bit m_act [N];
    int m_own [N];
    int m_age [N];
    int m_cd [2];
    bit m_prev [2];
    int m_ptr;
    logic [1:0] e_grant;
    logic [N-1:0] e_create;

    logic [1:0] c_grant, c_grant_pre, c_grant_after;
    logic [N-1:0] c_create, c_active, c_owner;
    logic [2:0] c_lc1, c_lc2;

    function automatic logic [N-1:0] act_vec();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_act[i];
        return v;
    endfunction

    function automatic logic [N-1:0] own_vec();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_act[i] && m_own[i] == 1;
        return v;
    endfunction

    function automatic int m_count(input int t);
        int c = 0;
        for (int i = 0; i < N; i++) if (m_act[i] && m_own[i] == t) c++;
        return c;
    endfunction

    function automatic int pick(input int t, input int skip);
        for (int i = 0; i < N; i++)
            if (!m_act[i] && i != skip && (SHARED || ((i >= N / 2) == (t == 1)))) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin m_act[i] = 0; m_own[i] = 0; m_age[i] = 0; end
        for (int t = 0; t < 2; t++) begin m_cd[t] = 0; m_prev[t] = 0; end
        m_ptr = 0;
    endtask

    task automatic model_flush();
        for (int i = 0; i < N; i++) m_act[i] = 0;
        for (int t = 0; t < 2; t++) m_cd[t] = 0;
    endtask

    task automatic model_hit(input logic [N-1:0] h);
        for (int i = 0; i < N; i++) if (h[i]) m_act[i] = 0;
    endtask

    task automatic model_tick(input logic [1:0] req, input logic ga);
        bit el [2];
        int s [2];
        e_grant = '0;
        e_create = '0;
        for (int t = 0; t < 2; t++) begin
            s[t] = -1;
            el[t] = req[t] && !m_prev[t] && ga && m_cd[t] == 0 && m_count(t) < MAXE && pick(t, -1) >= 0;
        end
        if (SHARED && el[0] && el[1]) begin
            s[m_ptr] = pick(m_ptr, -1);
            s[1 - m_ptr] = pick(1 - m_ptr, s[m_ptr]);
            m_ptr = 1 - m_ptr;
        end else
            for (int t = 0; t < 2; t++) if (el[t]) s[t] = pick(t, -1);
        for (int i = 0; i < N; i++)
            if (m_act[i]) begin
                m_age[i]--;
                if (m_age[i] == 0) m_act[i] = 0;
            end
        for (int t = 0; t < 2; t++) begin
            if (s[t] >= 0) begin
                m_act[s[t]] = 1;
                m_own[s[t]] = t;
                m_age[s[t]] = LIFE;
                m_cd[t] = CDN;
                e_grant[t] = 1'b1;
                e_create[s[t]] = 1'b1;
            end else if (m_cd[t] > 0)
                m_cd[t]--;
            if (!ga) m_cd[t] = 0;
            m_prev[t] = req[t];
        end
    endtask

    // one frame: vs low for exactly one cycle; capture outputs before, right after and one cycle after the tick
    task automatic frame(input logic [1:0] req, input logic ga);
        @(negedge CLK);
        fire_req = req;
        game_active = ga;
        vs = 1'b1;
        if (!ga) model_flush();
        @(negedge CLK);
        @(negedge CLK);
        vs = 1'b0;
        c_grant_pre = fire_grant;
        model_tick(req, ga);
        @(negedge CLK);
        vs = 1'b1;
        c_grant = fire_grant;
        c_create = slot_create;
        c_active = slot_active;
        c_owner = slot_owner & slot_active;
        @(negedge CLK);
        c_grant_after = fire_grant;
        c_lc1 = live_count1;
        c_lc2 = live_count2;
    endtask

    task automatic apply_hit(input logic [N-1:0] h);
        @(negedge CLK);
        slot_hit = h;
        model_hit(h);
        @(negedge CLK);
        slot_hit = '0;
        c_active = slot_active;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        n_cmp++; if (fire_grant !== 2'b00) begin n_bad++; $display("FAIL reset_grant: got %b want 00", fire_grant); end
        n_cmp++; if (slot_create !== '0) begin n_bad++; $display("FAIL reset_create: got %b want 0", slot_create); end
        n_cmp++; if (slot_active !== '0) begin n_bad++; $display("FAIL reset_active: got %b want 0", slot_active); end
        n_cmp++; if (slot_owner !== '0) begin n_bad++; $display("FAIL reset_owner: got %b want 0", slot_owner); end
        n_cmp++; if ({live_count1, live_count2} !== 6'd0) begin n_bad++; $display("FAIL reset_counts: got %0d/%0d want 0/0", live_count1, live_count2); end
    endtask

    task automatic test_single_shot();
        int held = 0;
        frame(2'b01, 1'b1);
        n_cmp++; if (c_grant_pre !== 2'b00) begin n_bad++; $display("FAIL ss_pre_tick: got %b want 00", c_grant_pre); end
        n_cmp++; if (c_grant !== 2'b01) begin n_bad++; $display("FAIL ss_grant: got %b want 01", c_grant); end
        n_cmp++; if (c_create !== 6'b000001) begin n_bad++; $display("FAIL ss_create: got %b want 000001", c_create); end
        n_cmp++; if (c_grant_after !== 2'b00) begin n_bad++; $display("FAIL ss_pulse: got %b want 00", c_grant_after); end
        n_cmp++; if (c_lc1 !== 3'd1) begin n_bad++; $display("FAIL ss_live1: got %0d want 1", c_lc1); end
        for (int k = 0; k < 4; k++) begin
            frame(2'b01, 1'b1);
            held += int'(c_grant[0]);
        end
        n_cmp++; if (held !== 0) begin n_bad++; $display("FAIL ss_held: got %0d extra grants want 0", held); end
        frame(2'b00, 1'b1);
    endtask

    task automatic test_limit_cooldown();
        logic want;
        frame(2'b00, 1'b0);
        frame(2'b00, 1'b1);
        for (int k = 0; k <= 44; k++) begin
            frame((k == 0 || k == 4 || k == 10 || k == 20 || k == 30 || k == 40) ? 2'b01 : 2'b00, 1'b1);
            want = (k == 0 || k == 10 || k == 20);
            n_cmp++; if (c_grant !== {1'b0, want}) begin n_bad++; $display("FAIL limit_grant k=%0d: got %b want %b", k, c_grant, {1'b0, want}); end
            n_cmp++; if (c_grant !== e_grant) begin n_bad++; $display("FAIL limit_model k=%0d: got %b want %b", k, c_grant, e_grant); end
        end
        n_cmp++; if (c_lc1 !== 3'd3) begin n_bad++; $display("FAIL limit_live1: got %0d want 3", c_lc1); end
    endtask

    task automatic test_contention();
        frame(2'b00, 1'b0);
        frame(2'b00, 1'b1);
        frame(2'b11, 1'b1);
        n_cmp++; if (c_create !== 6'b000011) begin n_bad++; $display("FAIL rr1_create: got %b want 000011", c_create); end
        n_cmp++; if (c_owner !== 6'b000010) begin n_bad++; $display("FAIL rr1_owner: got %b want 000010", c_owner); end
        repeat (9) frame(2'b00, 1'b1);
        frame(2'b11, 1'b1);
        n_cmp++; if (c_create !== 6'b001100) begin n_bad++; $display("FAIL rr2_create: got %b want 001100", c_create); end
        n_cmp++; if ((c_owner & c_create) !== 6'b000100) begin n_bad++; $display("FAIL rr2_owner: got %b want 000100", c_owner & c_create); end
        n_cmp++; if (c_create !== e_create) begin n_bad++; $display("FAIL rr2_model: got %b want %b", c_create, e_create); end
    endtask

    task automatic test_expiry_hit();
        frame(2'b00, 1'b0);
        frame(2'b01, 1'b1);
        repeat (LIFE - 1) frame(2'b00, 1'b1);
        n_cmp++; if (c_active !== 6'b000001) begin n_bad++; $display("FAIL exp_before: got %b want 000001", c_active); end
        frame(2'b00, 1'b1);
        n_cmp++; if (c_active !== 6'b000000) begin n_bad++; $display("FAIL exp_after: got %b want 000000", c_active); end
        n_cmp++; if (c_active !== act_vec()) begin n_bad++; $display("FAIL exp_model: got %b want %b", c_active, act_vec()); end
        frame(2'b00, 1'b0);
        for (int k = 0; k <= 20; k++) frame((k % 10 == 0) ? 2'b01 : 2'b00, 1'b1);
        apply_hit(6'b000100);
        n_cmp++; if (c_active !== 6'b000011) begin n_bad++; $display("FAIL hit_drop: got %b want 000011", c_active); end
        apply_hit(6'b100000);
        n_cmp++; if (c_active !== 6'b000011) begin n_bad++; $display("FAIL hit_free_ignored: got %b want 000011", c_active); end
        repeat (9) frame(2'b00, 1'b1);
        frame(2'b01, 1'b1);
        n_cmp++; if (c_create !== 6'b000100) begin n_bad++; $display("FAIL hit_reuse: got %b want 000100", c_create); end
    endtask

    task automatic test_flush_reset();
        logic [N-1:0] want_c, want_o;
        frame(2'b00, 1'b0);
        frame(2'b00, 1'b1);
        frame(2'b11, 1'b1);
        repeat (9) frame(2'b00, 1'b1);
        frame(2'b11, 1'b1);
        n_cmp++; if ({c_lc1, c_lc2} !== {3'd2, 3'd2}) begin n_bad++; $display("FAIL fl_live: got %0d/%0d want 2/2", c_lc1, c_lc2); end
        @(negedge CLK);
        game_active = 1'b0;
        model_flush();
        @(negedge CLK);
        n_cmp++; if (slot_active !== '0) begin n_bad++; $display("FAIL fl_active: got %b want 0", slot_active); end
        frame(2'b00, 1'b1);
        for (int k = 0; k <= 20; k++) frame((k % 10 == 0) ? 2'b11 : 2'b00, 1'b1);
        @(negedge CLK);
        RESET = 1'b1;
        fire_req = 2'b01;
        @(negedge CLK);
        n_cmp++;
        if ({fire_grant, slot_create, slot_active, slot_owner, live_count1, live_count2} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid: got grant=%b create=%b active=%b owner=%b lc=%0d/%0d want all 0",
                     fire_grant, slot_create, slot_active, slot_owner, live_count1, live_count2);
        end
        vs = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        @(negedge CLK);
        n_cmp++; if ({fire_grant, slot_create} !== '0) begin n_bad++; $display("FAIL rst_no_create: got %b/%b want 0", fire_grant, slot_create); end
        vs = 1'b1;
        frame(2'b00, 1'b1);
        frame(2'b11, 1'b1);
        want_c = SHARED ? 6'b000011 : 6'b001001;
        want_o = SHARED ? 6'b000010 : 6'b001000;
        n_cmp++; if (c_create !== want_c) begin n_bad++; $display("FAIL rst_ptr_create: got %b want %b", c_create, want_c); end
        n_cmp++; if (c_owner !== want_o) begin n_bad++; $display("FAIL rst_ptr_owner: got %b want %b", c_owner, want_o); end
    endtask

    task automatic test_unshared();
        frame(2'b00, 1'b0);
        frame(2'b00, 1'b1);
        frame(2'b10, 1'b1);
        n_cmp++; if (c_create !== 6'b001000) begin n_bad++; $display("FAIL us_create: got %b want 001000", c_create); end
        n_cmp++; if (c_owner[3] !== 1'b1) begin n_bad++; $display("FAIL us_owner3: got %b want 1", c_owner[3]); end
        for (int k = 1; k <= 30; k++) begin
            frame((k % 10 == 0) ? 2'b10 : 2'b00, 1'b1);
            n_cmp++; if ((c_create & 6'b000111) !== '0) begin n_bad++; $display("FAIL us_low_half k=%0d: got %b want 000", k, c_create[2:0]); end
        end
        n_cmp++; if (c_active !== 6'b111000) begin n_bad++; $display("FAIL us_active: got %b want 111000", c_active); end
    endtask

    task automatic test_random();
        logic [N-1:0] h;
        frame(2'b00, 1'b0);
        for (int k = 0; k < 400; k++) begin
            frame(2'($urandom_range(0, 3)), $urandom_range(0, 29) != 0);
            n_cmp++; if (c_grant !== e_grant) begin n_bad++; $display("FAIL rnd_grant k=%0d: got %b want %b", k, c_grant, e_grant); end
            n_cmp++; if (c_create !== e_create) begin n_bad++; $display("FAIL rnd_create k=%0d: got %b want %b", k, c_create, e_create); end
            n_cmp++; if (c_active !== act_vec()) begin n_bad++; $display("FAIL rnd_active k=%0d: got %b want %b", k, c_active, act_vec()); end
            n_cmp++; if (c_owner !== own_vec()) begin n_bad++; $display("FAIL rnd_owner k=%0d: got %b want %b", k, c_owner, own_vec()); end
            n_cmp++;
            if ({c_lc1, c_lc2} !== {3'(m_count(0)), 3'(m_count(1))}) begin
                n_bad++;
                $display("FAIL rnd_live k=%0d: got %0d/%0d want %0d/%0d", k, c_lc1, c_lc2, m_count(0), m_count(1));
            end
            if ($urandom_range(0, 3) == 0) begin
                h = N'($urandom_range(0, (1 << N) - 1));
                apply_hit(h);
                n_cmp++; if (c_active !== act_vec()) begin n_bad++; $display("FAIL rnd_hit k=%0d: got %b want %b", k, c_active, act_vec()); end
            end
        end
    endtask

    initial begin
        RESET = 1'b1;
        vs = 1'b1;
        game_active = 1'b1;
        fire_req = '0;
        slot_hit = '0;
        model_reset();
        test_reset();
        test_single_shot();
        test_limit_cooldown();
        if (SHARED) test_contention();
        test_expiry_hit();
        test_flush_reset();
        if (!SHARED) test_unshared();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not complete, %0d compared so far", n_cmp);
        $fatal(1);
    end
endmodule

// File: doc/bullet_pool_arbiter.md
# bullet_pool_arbiter

Allocates a shared pool of bullet slots between the two tanks. It edge-detects each tank's fire request once per frame and enforces a per-tank live-bullet limit and a re-fire cooldown. When both tanks contend for the last free slot, a round-robin pointer picks the winner. The block sits between the tank modules' ShootBullet outputs and the bullet instances: it drives each bullet's create input and retires slots on expiry or hit.

## Interface
- NUM_SLOTS, 6: bullet slots in the pool; even, 2..8.
- MAX_PER_TANK, 3: maximum simultaneously live bullets per tank; ≤ 7.
- LIFETIME, 10'd300: slot life in frames; 1..1023.
- COOLDOWN, 6'd8: frames between grants to the same tank; 0..63.

Ports:
- CLK  in  1  system clock, 50 MHz.
- RESET  in  1  reset, synchronous, active-high.
- vs  in  1  VGA vertical sync, active-low, synchronous to CLK.
- game_active  in  1  high while a round is in play.
- fire_req  in  2  level fire request; bit 0 is tank1, bit 1 is tank2.
- slot_hit  in  NUM_SLOTS  per-slot tank-collision flag.
- fire_grant  out  2  one-cycle pulse, per tank, when a request is accepted.
- slot_create  out  NUM_SLOTS  one-cycle pulse to the bullet's create input.
- slot_owner  out  NUM_SLOTS  0 means tank1 owns the slot, 1 means tank2; held while the slot is active.
- slot_active  out  NUM_SLOTS  slot is FLYING.
- live_count1, live_count2  out  3  number of active slots owned by each tank.

## Operation
- Frame tick: vs is registered into vs_d. tick = vs_d & ~vs, a single CLK cycle on the falling edge of vs. All frame-rate state advances only on tick.
- Request edge: fire_req is sampled on each tick into req_prev. A request is new when fire_req[t] is high and req_prev[t] is low. A held button yields exactly one request.
- Eligibility of tank t at a tick, all of which must hold:
  - the request is new;
  - game_active is high;
  - cooldown[t] == 0;
  - live_count_t < MAX_PER_TANK;
  - a free slot is available to t.
- Allocation:
  - A single eligible tank takes the lowest-index free slot.
  - If both tanks are eligible and two or more slots are free, both are granted. The tank at the round-robin pointer takes the lowest free slot; the other takes the next free slot.
  - If both are eligible and only one slot is free, the pointer's tank wins. The loser's request is dropped and needs a new press.
  - The pointer toggles after every contested tick. It does not change on uncontested grants.
- Slot FSM, one per slot:
  - FREE → FLYING on grant: slot_create pulses, slot_owner is loaded, age is loaded with LIFETIME.
  - FLYING: age decrements on each tick. At age == 1 with a tick, the slot returns to FREE. slot_hit[i] returns it to FREE on the next cycle; the hit takes priority over age expiry on the same cycle.
  - slot_hit on a FREE slot is ignored.
- Cooldown: loaded with COOLDOWN on grant and decremented on each non-zero tick. COOLDOWN = 0 disables it.
- game_active low forces every slot to FREE on the next cycle, clears all cooldowns and blocks new grants.
- live counts are a registered popcount of (slot_active & owner match).

## Timing
- Reset values:
  - all outputs 0;
  - all slots FREE;
  - cooldowns, ages and req_prev at 0;
  - round-robin pointer at tank1.
- RESET asserted mid-flight clears all slots within one cycle. No slot_create is emitted in the cycle after RESET deasserts.
- Latency: tick at cycle n gives fire_grant and slot_create at cycle n+1. slot_active is high from n+1.
- slot_hit at cycle n drops slot_active at n+1. The slot can be reallocated on the next tick.
- Expiry at tick n drops slot_active at n+1. The slot is not reusable at tick n itself.

## Configuration
- BULLET_POOL_SHARED_EN defined: any free slot may go to either tank, with round-robin contention as above.
- BULLET_POOL_SHARED_EN undefined:
  - slots 0..NUM_SLOTS/2-1 belong to tank1 and the rest to tank2;
  - slot_owner is constant;
  - contention never arises and the pointer logic is removed;
  - MAX_PER_TANK is clamped to NUM_SLOTS/2.

## Structure
- Shared package tank_game_pkg holds:
  - enum slot_state_e {SLOT_FREE, SLOT_FLYING};
  - constants TANK1 = 1'b0 and TANK2 = 1'b1;
  - widths AGE_W = 10 and CD_W = 6.
- Sub-module bullet_slot_ctrl: one slot's FSM, age counter and owner register, with inputs grant, owner_in, hit, tick and flush. It is generated NUM_SLOTS times.
- The allocation/priority encoder and the cooldowns stay in the top level.

## Test plan
- Single shot: tank1 presses and holds for 5 frames → exactly one fire_grant[0]. slot_create[0] fires one cycle after the tick; live_count1 = 1.
- Limit and cooldown: tank1 presses 5 times, 10 frames apart → grants 1–3, presses 4–5 refused at live_count1 = 3. A re-press at 4 frames after a grant is refused (COOLDOWN = 8).
- Contention with 1 free slot:
  - both tanks press on the same tick → tank1 is granted, tank2 is dropped, the pointer toggles;
  - the next contest → tank2 wins.
- Expiry and hit:
  - LIFETIME = 3 → slot_active falls the cycle after the 3rd tick;
  - slot_hit on slot 2 → falls next cycle, and slot 2 is reused at the next grant.
- Flush and reset: game_active falls with 4 slots live → all slot_active are 0 the next cycle. RESET mid-flight → all outputs 0 and the pointer is at tank1.
- Without BULLET_POOL_SHARED_EN: tank2 fires first → slot_create[3] and slot_owner[3] = 1. Slots 0–2 never go to tank2.
